// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, NOP encoding, PC step
// and the fetch FSM state type.
package pipe_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {instr, pc} words; head is presented combinationally
// so decode sees a returned word the cycle after it is pushed.
module fetch_queue
  import pipe_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [2*XLEN-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(QDEPTH):0]  count,
  output logic                     head_valid,
  output logic [2*XLEN-1:0]        head_data
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  logic [2*XLEN-1:0] mem [QDEPTH];
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [CW-1:0]     count_reg;

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr_reg] <= push_data;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != '0);
  assign head_data  = mem[rd_ptr_reg];
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request, small return queue,
// redirect squash. Define FETCH_PERF_CNT_EN to build the bubble counter.
module instr_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic        fetch_valid,
  output logic [31:0] instructionout,
  output logic [31:0] delayout,
  output logic [31:0] delay2out,
  output logic [31:0] bubble_count
);
  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state_reg, state_next;
  logic [31:0]   pc_reg;
  logic [31:0]   req_addr_reg;
  logic [CW-1:0] q_count;
  logic          q_head_valid;
  logic [63:0]   q_head;
  fetch_entry_t  head_entry;
  fetch_entry_t  push_entry;
  logic          pop, in_busy, push, space;
  logic [CW:0]   occ_next;

  assign pop      = fetch_valid & ~stall & ~redirect_valid;
  assign in_busy  = imem_rvalid & (state_reg == BUSY);
  assign push     = in_busy & ~redirect_valid;
  assign occ_next = {1'b0, q_count} + (CW+1)'(in_busy) - (CW+1)'(pop);
  assign space    = occ_next < (CW+1)'(QDEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // An unanswered request at redirect time must still be drained.
  always_comb begin
    state_next = state_reg;
    if (redirect_valid) begin
      state_next = ((state_reg != IDLE) && !imem_rvalid) ? DRAIN : IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = imem_req ? BUSY : IDLE;
        BUSY:    if (imem_rvalid) state_next = imem_req ? BUSY : IDLE;
        DRAIN:   if (imem_rvalid) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    if (!reset && !redirect_valid && space)
      imem_req = (state_reg == IDLE) || ((state_reg == BUSY) && imem_rvalid);
  end

  assign imem_addr = pc_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg       <= RESET_PC & ~32'h3;
      req_addr_reg <= '0;
    end else if (redirect_valid) begin
      pc_reg <= redirect_target & ~32'h3;
    end else if (imem_req) begin
      pc_reg       <= pc_reg + PC_STEP;
      req_addr_reg <= pc_reg;
    end
  end

  assign push_entry = '{instr: imem_rdata, pc: req_addr_reg};

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (q_count),
    .head_valid (q_head_valid),
    .head_data  (q_head)
  );

  assign head_entry     = fetch_entry_t'(q_head);
  assign fetch_valid    = q_head_valid;
  assign instructionout = q_head_valid ? head_entry.instr : NOP_INSTR;
  assign delayout       = q_head_valid ? head_entry.pc + PC_STEP : '0;
  assign delay2out      = q_head_valid ? head_entry.pc + PC_STEP + PC_STEP : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bubble_reg <= '0;
    else if (!fetch_valid && !stall && (bubble_reg != 32'hFFFF_FFFF))
      bubble_reg <= bubble_reg + 32'd1;
  end
  assign bubble_count = bubble_reg;
`else
  assign bubble_count = '0;
`endif

  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && (state_reg == IDLE)))
    else $error("imem_rvalid with no request outstanding");
endmodule
